mult_32_bit_seq: RTL and testbench

Sequential 32-bit signed multiplier for the MIPS datapath, producing the 64-bit `mult` result in HI/LO. It reuses the add/subtract arithmetic style of the 32-bit adder/subtractor blocks, but accumulates over 32 shift-and-add cycles instead of computing in one step. It sits beside the ALU and is started by the control unit when a `mult` instruction issues. Control stalls on `busy` and captures HI/LO when `done` pulses.

---
 rtl/mult_32_bit_seq.sv | 95 +++++++++
 tb/tb_mult_32_bit_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mult_32_bit_seq.sv
// Sequential signed multiplier for the MIPS mult instruction: multiplies the operand
// magnitudes by shift-and-add over WIDTH cycles, then applies the sign in a final cycle.
module mult_32_bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start; done may pulse here
    // RUN   | one shift-and-add iteration per clock, cnt 0..WIDTH-1
    // FIX   | apply sign to accumulator, load hi/lo, pulse done
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2 * WIDTH)'(1);

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_mag   = a[WIDTH-1] ? (~a + ONE_W) : a;
    assign b_mag   = b[WIDTH-1] ? (~b + ONE_W) : b;
    assign addend  = mplier[0] ? mcand : '0;
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign product = neg ? (~acc + ONE_P) : acc;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Carry out of the upper-half add becomes the new MSB after the shift.
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    {hi, lo} <= product;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_32_bit_seq.sv
// Scoreboard bench for mult_32_bit_seq: expected products are queued at start and
// compared against hi/lo whenever done pulses.
module tb_mult_32_bit_seq;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;

    always #5 clk = ~clk;

    mult_32_bit_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    // Result checker: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (!reset && done) begin
            check("busy_with_done", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("result", {hi, lo}, sb_exp);
            end
        end
    end

    // lat counts clock edges after the accept edge until done is seen.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int poke_at,
                          output int lat, output int busy_cnt);
        logic [63:0] prev;
        @(negedge clk);
        prev  = {hi, lo};
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(x, y));
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == poke_at) begin
                a     = 32'd5;
                b     = 32'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (lat == 20) check("hold_hilo", {hi, lo}, prev);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) check("timeout", 64'(done), 64'd1);
    endtask

    logic [31:0] tab_a[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] tab_b[4] = '{32'd6,         32'h8000_0000, 32'hFFFF_FFFF, 32'd1};

    initial begin
        int lat;
        int bc;
        int k;
        logic seen;

        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'd7, 32'd6, -1, lat, bc);
        check("latency_7x6", 64'(lat), 64'd33);
        check("busy_cycles_7x6", 64'(bc), 64'd33);
        check("lo_7x6", 64'(lo), 64'h2A);

        for (int i = 0; i < 4; i++) begin
            run_op(tab_a[i], tab_b[i], -1, lat, bc);
            check("latency_tab", 64'(lat), 64'd33);
        end

        // start during an operation must be ignored
        run_op(32'd128, 32'd64, 10, lat, bc);
        check("latency_poke", 64'(lat), 64'd33);
        check("lo_poke", 64'(lo), 64'h2000);

        // back-to-back: start held in the done cycle
        run_op(32'd3, 32'd4, -1, lat, bc);
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        sb.push_back(model(32'd6, 32'd7));
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_b2b_accept", 64'(busy), 64'd1);
        k = 1;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("b2b_spacing", 64'(k), 64'd34);
        check("lo_b2b", 64'(lo), 64'h2A);

        // asynchronous reset mid-operation
        @(negedge clk);
        a     = 32'd7;
        b     = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("no_activity_after_abort", 64'(seen), 64'd0);

        run_op(32'd32, 32'd16, -1, lat, bc);
        check("latency_after_reset", 64'(lat), 64'd33);
        check("lo_after_reset", 64'(lo), 64'h200);

        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
